// File: rtl/johnson_pkg.sv
// Shared types and constants for the 4-bit Johnson code decoder.
// Holds the lock FSM states and the ordered table of legal codes.
package johnson_pkg;

  localparam int JOHNSON_W      = 4;
  localparam int JOHNSON_STATES = 8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // Legal codes packed in phase order: entry i sits at bits [4*i +: 4].
  localparam logic [JOHNSON_W*JOHNSON_STATES-1:0] LEGAL_CODES = {
    4'b1000, 4'b1100, 4'b1110, 4'b1111,
    4'b0111, 4'b0011, 4'b0001, 4'b0000
  };

  function automatic logic [JOHNSON_W-1:0] legal_code(input int unsigned i);
    return LEGAL_CODES[i*JOHNSON_W +: JOHNSON_W];
  endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality test and phase decode of one Johnson word.
// Legal means thermometer form; illegal words decode to index 0.
module johnson_code_check
  import johnson_pkg::*;
(
  input  logic [JOHNSON_W-1:0] code,
  output logic                 legal,
  output logic [2:0]           index
);

  logic [1:0] edges;
  logic [2:0] ones;

  always_comb begin
    edges = 2'(code[3] ^ code[2]) + 2'(code[2] ^ code[1]) + 2'(code[1] ^ code[0]);
    ones  = 3'(code[0]) + 3'(code[1]) + 3'(code[2]) + 3'(code[3]);
    legal = (edges <= 2'd1);
    index = 3'd0;
    if (legal) begin
      // Upper half of the cycle counts the zeros that have shifted in.
      index = code[3] ? (3'd4 + (3'd4 - ones)) : ones;
    end
  end

endmodule

// File: rtl/johnson_decoder4.sv
// Johnson code decoder with lock FSM and sequence-error counter; 1-cycle latency, no backpressure.
// err_count register exists only when JOHNSON_DEC_ERRCNT_EN is defined; otherwise it is tied to 0.
module johnson_decoder4
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [JOHNSON_W-1:0] code,
  output logic                 out_valid,
  output logic [2:0]           index,
  output logic                 illegal,
  output logic                 seq_err,
  output logic                 locked,
  output logic [ERR_W-1:0]     err_count
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

  logic        dec_legal;
  logic [2:0]  dec_index;
  lock_state_t state, state_nxt;
  logic [2:0]  expected, expected_nxt;
  logic [3:0]  run, run_nxt;
  logic        seq_err_nxt;

  johnson_code_check u_check (
    .code  (code),
    .legal (dec_legal),
    .index (dec_index)
  );

  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    run_nxt      = run;
    seq_err_nxt  = 1'b0;
    if (in_valid) begin
      case (state)
        HUNT: begin
          if (dec_legal) begin
            expected_nxt = dec_index + 3'd1;
            run_nxt      = 4'd0;
            state_nxt    = CHECK;
          end
        end
        CHECK: begin
          if (!dec_legal) begin
            state_nxt = HUNT;
          end else if (dec_index == expected) begin
            run_nxt      = run + 4'd1;
            expected_nxt = dec_index + 3'd1;
            if (run + 4'd1 == LOCK_TARGET) state_nxt = LOCKED;
          end else begin
            // A legal but out-of-order code restarts the run from that phase.
            expected_nxt = dec_index + 3'd1;
            run_nxt      = 4'd0;
          end
        end
        LOCKED: begin
          if (dec_legal && dec_index == expected) begin
            expected_nxt = dec_index + 3'd1;
          end else begin
            seq_err_nxt = 1'b1;
            state_nxt   = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      expected  <= 3'd0;
      run       <= 4'd0;
      out_valid <= 1'b0;
      index     <= 3'd0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      run       <= run_nxt;
      out_valid <= in_valid;
      seq_err   <= seq_err_nxt;
      if (in_valid) begin
        index   <= dec_index;
        illegal <= ~dec_legal;
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (seq_err_nxt && err_cnt_q != {ERR_W{1'b1}}) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/johnson_decoder4.md
# johnson_decoder4

Receive-side companion to the 4-bit Johnson counter: samples a Johnson-coded word each valid cycle, decodes it to a 3-bit binary phase index, and flags illegal codes. It also tracks sequence continuity with a lock state machine and counts post-lock sequence errors. It sits wherever a Johnson-counter output crosses into logic that needs a binary phase or a health indication.

## Interface
- `LOCK_CNT`, default 3: consecutive correct successors required in CHECK before entering LOCKED (range 1..15).
- `ERR_W`, default 8: width of the error counter.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `code` is sampled this cycle.
- `code`  input  4  Johnson-coded word.
- `out_valid`  output  1  registered copy of `in_valid`.
- `index`  output  3  decoded phase 0..7; holds 0 when the code is illegal.
- `illegal`  output  1  sampled code is not one of the 8 legal codes; qualified by `out_valid`.
- `seq_err`  output  1  one-cycle pulse: LOCKED and the sample is illegal or not the expected successor.
- `locked`  output  1  FSM is in LOCKED.
- `err_count`  output  ERR_W  saturating count of `seq_err` pulses.

## Operation
- Legal codes map to indices: 0000→0, 0001→1, 0011→2, 0111→3, 1111→4, 1110→5, 1100→6, 1000→7. All other codes are illegal.
- Legality test: at most one bit-to-bit transition across `code[3:0]` (thermometer form).
- Index rule: if `code[3]`=0, index = popcount(code). If `code[3]`=1, index = 4 + number of zero bits.
- The lock FSM advances only on `in_valid`=1 cycles. Idle cycles change nothing.
- `expected` (3 bits) is the successor register, always `(index+1) mod 8`, wrapping 7→0.
- HUNT: on a legal sample, load `expected`, clear the run counter, go to CHECK. An illegal sample stays in HUNT.
- CHECK: a legal sample equal to `expected` increments the run counter and updates `expected`. When the counter reaches `LOCK_CNT`, go to LOCKED.
- CHECK: any other sample goes to HUNT, with no error reported. A legal mismatching sample re-seeds `expected` and re-enters CHECK instead of going to HUNT.
- LOCKED: a sample equal to `expected` updates `expected` and stays in LOCKED.
- LOCKED: an illegal or mismatching sample (including a repeated code) pulses `seq_err`, increments `err_count`, and goes to HUNT.
- `err_count` saturates at all-ones and is not cleared by loss of lock. Only reset clears it.
- Simultaneous events: the transition into HUNT and the counter increment take effect on the same edge.

## Timing
- Latency is one cycle. `out_valid`, `index`, `illegal`, `seq_err`, and `locked` all reflect the sample taken at the previous rising edge.
- `locked` rises on the edge that accepts the `LOCK_CNT`-th correct successor. That is `LOCK_CNT+1` valid samples after the first legal sample.
- `seq_err` is high for exactly one cycle per error. `locked` falls on the same edge that `seq_err` rises.
- Reset values: `out_valid`=0, `index`=0, `illegal`=0, `seq_err`=0, `locked`=0, `err_count`=0. Internally, FSM=HUNT, `expected`=0, run counter=0.
- Reset asserted mid-operation clears all state immediately, without waiting for `clk`.

## Configuration
- `JOHNSON_DEC_ERRCNT_EN` defined: `err_count` register and saturating increment are present.
- Macro undefined: `err_count` is driven constant 0 and no counter flops are synthesized. `seq_err` and the FSM are unchanged.

## Structure
- Shared package `johnson_pkg` holds:
  - the FSM state enum (HUNT, CHECK, LOCKED);
  - the `JOHNSON_W`=4 constant and the `JOHNSON_STATES`=8 constant;
  - a legal-code table, used by the bench.
- Sub-module `johnson_code_check`: combinational legality test and index decode of a single word, reused by the bench's scoreboard.

## Test plan
- Reset, then stream 0000,0001,0011,0111,1111 → `locked`=1 one cycle after the 4th sample (LOCK_CNT=3). Indices 0,1,2,3,4, `illegal`=0 throughout.
- Locked stream reaches 1000 followed by 0000 → index 7 then 0, no `seq_err` (wrap-around).
- While locked, inject 0101 → `illegal`=1, `seq_err` 1-cycle pulse, `err_count`=1, `locked`=0 on the same cycle.
- While locked, inject 0011 then 0011 (repeat) → `seq_err` pulse on the repeat, `illegal`=0, FSM back in HUNT.
- Force 300 errors with ERR_W=8 → `err_count` holds 255. With the macro undefined, `err_count` stays 0.
- Assert `rst_n`=0 mid-CHECK between clock edges → all outputs are 0 immediately. After release, lock again needs 4 valid legal samples.
